sseg_scan_ctrl: RTL and testbench
=================================

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal range > BLANK_CYCLES+1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, dead-time cycles at the start of each slot with all anodes off.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  scan run (1) / stop (0).
REQ-006 SHALL have port load  input  1  single-cycle strobe capturing digits_i into the shadow register.
REQ-007 SHALL have port digits_i  input  4 x BCDnumber_t  display values; index 0 is the rightmost digit.
REQ-008 SHALL have port hex  output  BCDnumber_t  digit currently driven, to the BCD_to_sseg decoder.
REQ-009 SHALL have port an  output  4  anode select, active-low, one-hot-low or all-ones.
REQ-010 SHALL have port blank  output  1  high when no anode is active.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at end of digit-3 slot.

Function
REQ-012 SHALL implement states IDLE, BLANK, SHOW; all outputs registered.
REQ-013 IDLE: an=4'hF, blank=1, slot counter=0, idx=0; enable=1 -> BLANK next cycle.
REQ-014 BLANK: an=4'hF, blank=1, lasts exactly BLANK_CYCLES cycles -> SHOW.
REQ-015 SHOW: an[idx]=0, others 1, hex=active[idx], blank=0, lasts REFRESH_DIV-BLANK_CYCLES cycles -> BLANK with idx+1.
REQ-016 idx SHALL wrap 3 -> 0; frame_done SHALL pulse in the cycle BLANK of idx 0 is entered after a wrap.
REQ-017 Slot counter width SHALL be $clog2(REFRESH_DIV); counter restarts at 0 on every state entry.
REQ-018 load=1 SHALL write digits_i into shadow and set pending, in any state.
REQ-019 At a frame boundary (wrap 3 -> 0) or on IDLE -> BLANK, if pending, active SHALL take shadow and pending SHALL clear.
REQ-020 load coincident with a frame boundary: active takes the previous shadow contents, shadow takes new digits_i, pending remains set (applied at next boundary).
REQ-021 enable=0 in any state SHALL force IDLE next cycle (an=4'hF, blank=1); no frame_done is issued for the aborted frame.
REQ-022 Displayed data SHALL never change within a frame (tear-free).
REQ-023 In BLANK and IDLE, hex SHALL be all zeros.

Reset
REQ-024 rst_n=0 at a clock edge SHALL set: state IDLE, idx 0, counter 0, an=4'hF, hex=0, blank=1, frame_done=0, shadow=0, active=0, pending=0.
REQ-025 Reset asserted mid-SHOW SHALL take effect on that edge, overriding enable and load.

Configuration
REQ-026 Macro SSEG_LEADING_ZERO_BLANK_EN SHALL control leading-zero suppression.
REQ-027 With the macro defined: in SHOW of idx i (3..1), an SHALL stay 4'hF and blank=1 if active digits 3..i all have digito=0 and dp=0; digit 0 is never suppressed; slot timing is unchanged.
REQ-028 Without the macro: every digit is driven in its SHOW slot regardless of value.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-029 Reset, then enable=1, load digits {3,2,1,0}=4,3,2,1 -> an sequence 1110,1101,1011,0111 each low for 6 cycles after 2 blank cycles; hex.digito 1,2,3,4; frame_done every 32 cycles.
REQ-030 load new value {9,9,9,9} during idx 1 SHOW -> current frame still shows 4,3,2,1; next frame shows 9 on all digits.
REQ-031 load exactly at the wrap cycle with pending set -> older shadow displayed next frame, newer value the frame after.
REQ-032 enable=0 during idx 2 SHOW -> next cycle an=4'hF, blank=1, no frame_done; re-enable -> restarts at idx 0 after 2 blank cycles.
REQ-033 rst_n=0 for one cycle mid-SHOW -> next cycle all outputs at REQ-024 values; active cleared to 0.
REQ-034 With SSEG_LEADING_ZERO_BLANK_EN and digits {0,0,5,0} -> idx 3 and 2 slots keep an=4'hF, idx 1 shows 5, idx 0 shows 0; without macro all four driven.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with tear-free double-buffered digits.
// Optional leading-zero suppression: define SSEG_LEADING_ZERO_BLANK_EN.
package sseg_pkg;
  typedef struct packed {
    logic       dp;
    logic [3:0] digito;
  } BCDnumber_t;
endpackage

module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  BCDnumber_t [3:0] digits_i,
  output BCDnumber_t       hex,
  output logic [3:0]       an,
  output logic             blank,
  output logic             frame_done
);

  localparam int unsigned   CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t           state, state_nx;
  logic [1:0]       idx, idx_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             wrap, commit;
  logic             pending;
  logic             suppress;
  BCDnumber_t [3:0] shadow, active;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + 1'b1;
    wrap     = 1'b0;
    commit   = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          cnt_nx   = '0;
          commit   = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = SHOW;
            cnt_nx   = '0;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            idx_nx   = idx + 2'd1;
            wrap     = (idx == 2'd3);
            commit   = (idx == 2'd3);
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic [3:0] zero_dig;

  // A slot is dark only while it and every digit to its left read zero with dp off.
  always_comb begin
    zero_dig[0] = (active[0] == '0);
    zero_dig[1] = (active[1] == '0);
    zero_dig[2] = (active[2] == '0);
    zero_dig[3] = (active[3] == '0);
    case (idx_nx)
      2'd3:    suppress = zero_dig[3];
      2'd2:    suppress = &zero_dig[3:2];
      2'd1:    suppress = &zero_dig[3:1];
      default: suppress = 1'b0;
    endcase
  end
`else
  always_comb begin
    suppress = 1'b0;
  end
`endif

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      an         <= '1;
      hex        <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      frame_done <= wrap;

      if (commit && pending)
        active <= shadow;

      if (load) begin
        shadow  <= digits_i;
        pending <= 1'b1;
      end else if (commit && pending) begin
        pending <= 1'b0;
      end

      if (state_nx == SHOW && !suppress) begin
        an    <= ~(4'b0001 << idx_nx);
        blank <= 1'b0;
      end else begin
        an    <= '1;
        blank <= 1'b1;
      end

      hex <= (state_nx == SHOW) ? active[idx_nx] : '0;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: expected frames are queued as digits are loaded
// and compared against a time-based scan model at every falling edge.
module tb_sseg_scan_ctrl;
  import sseg_pkg::*;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef BCDnumber_t [3:0] frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  frame_t     digits_i = '0;
  BCDnumber_t hex;
  logic [3:0] an;
  logic       blank;
  logic       frame_done;

  int     total = 0;
  int     bad = 0;
  bit     checking = 1'b0;
  bit     m_run = 1'b0;
  int     m_t = 0;
  frame_t frame_q[$];
  frame_t cur = '0;

  logic [3:0] e_an;
  logic       e_blank, e_fd;
  BCDnumber_t e_hex;
  int         ph, sl;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .digits_i   (digits_i),
    .hex        (hex),
    .an         (an),
    .blank      (blank),
    .frame_done (frame_done)
  );

  function automatic frame_t mk(int d3, int d2, int d1, int d0);
    frame_t r;
    r = '0;
    r[3].digito = 4'(d3);
    r[2].digito = 4'(d2);
    r[1].digito = 4'(d1);
    r[0].digito = 4'(d0);
    return r;
  endfunction

  function automatic bit sup(frame_t f, int slot);
    if (!LZB || slot == 0) return 1'b0;
    for (int k = 3; k >= slot; k--)
      if (f[k] !== '0) return 1'b0;
    return 1'b1;
  endfunction

  // Scan timeline: m_t counts cycles since the first blank slot after enable.
  always @(posedge clk) begin
    if (!rst_n || !enable) begin
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_t   = 0;
    end else begin
      m_t = m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      e_an = '1; e_blank = 1'b1; e_fd = 1'b0; e_hex = '0;
      if (m_run) begin
        if (m_t % FRAME == 0) begin
          total++;
          if (frame_q.size() == 0) begin
            bad++;
            $display("FAIL frame_q: t=%0d got empty queue, required a queued frame", m_t);
          end else begin
            cur = frame_q.pop_front();
          end
        end
        ph   = m_t % RD;
        sl   = (m_t / RD) % 4;
        e_fd = (m_t >= FRAME) && (m_t % FRAME == 0);
        if (ph >= BC) begin
          e_hex = cur[sl];
          if (!sup(cur, sl)) begin
            e_an    = ~(4'b0001 << sl);
            e_blank = 1'b0;
          end
        end
      end
      total++;
      if (an !== e_an) begin
        bad++; $display("FAIL an: t=%0d run=%0d got %b required %b", m_t, m_run, an, e_an);
      end
      total++;
      if (blank !== e_blank) begin
        bad++; $display("FAIL blank: t=%0d run=%0d got %b required %b", m_t, m_run, blank, e_blank);
      end
      total++;
      if (hex !== e_hex) begin
        bad++; $display("FAIL hex: t=%0d run=%0d got %h required %h", m_t, m_run, hex, e_hex);
      end
      total++;
      if (frame_done !== e_fd) begin
        bad++; $display("FAIL frame_done: t=%0d run=%0d got %b required %b", m_t, m_run, frame_done, e_fd);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_t(int k);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(m_run && m_t == k) && n < 2000);
    total++;
    if (!(m_run && m_t == k)) begin
      bad++;
      $display("FAIL wait_t: reached t=%0d run=%0d, required t=%0d", m_t, m_run, k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; load = 1'b0;
    cyc(3);
    total++; if (an !== 4'hF) begin bad++; $display("FAIL reset_an: got %b required 1111", an); end
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL reset_blank: got %b required 1", blank); end
    total++; if (hex !== '0) begin bad++; $display("FAIL reset_hex: got %h required 00", hex); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b required 0", frame_done); end
    rst_n = 1'b1;
    checking = 1'b1;
    cyc(2);
  endtask

  task automatic test_basic_scan();
    digits_i = mk(4, 3, 2, 1);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    frame_q.push_back(mk(4, 3, 2, 1));
    frame_q.push_back(mk(4, 3, 2, 1));
    enable = 1'b1;
    wait_t(42);
    total++; if (an !== 4'b1101) begin bad++; $display("FAIL basic_an_idx1: got %b required 1101", an); end
    total++; if (hex.digito !== 4'd2) begin bad++; $display("FAIL basic_hex_idx1: got %0d required 2", hex.digito); end
    wait_t(63);
  endtask

  task automatic test_midframe_load();
    frame_q.push_back(mk(4, 3, 2, 1));
    frame_q.push_back(mk(9, 9, 9, 9));
    frame_q.push_back(mk(9, 9, 9, 9));
    wait_t(75);
    digits_i = mk(9, 9, 9, 9);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    wait_t(128);
  endtask

  task automatic test_load_at_wrap();
    frame_q.push_back(mk(5, 5, 5, 5));
    frame_q.push_back(mk(6, 6, 6, 6));
    frame_q.push_back(mk(6, 6, 6, 6));
    wait_t(130);
    digits_i = mk(5, 5, 5, 5);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    wait_t(159);
    digits_i = mk(6, 6, 6, 6);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    wait_t(224);
  endtask

  task automatic test_enable_abort();
    wait_t(243);
    enable = 1'b0;
    cyc(1);
    total++; if (an !== 4'hF) begin bad++; $display("FAIL abort_an: got %b required 1111", an); end
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL abort_blank: got %b required 1", blank); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL abort_fd: got %b required 0", frame_done); end
    cyc(3);
    frame_q.push_back(mk(6, 6, 6, 6));
    frame_q.push_back(mk(6, 6, 6, 6));
    enable = 1'b1;
    wait_t(36);
  endtask

  task automatic test_reset_mid_show();
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL pre_reset_an: got %b required 1110", an); end
    rst_n = 1'b0;
    load = 1'b1;
    digits_i = mk(7, 7, 7, 7);
    cyc(1);
    total++; if (an !== 4'hF) begin bad++; $display("FAIL midrst_an: got %b required 1111", an); end
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL midrst_blank: got %b required 1", blank); end
    total++; if (hex !== '0) begin bad++; $display("FAIL midrst_hex: got %h required 00", hex); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL midrst_fd: got %b required 0", frame_done); end
    rst_n = 1'b1;
    load = 1'b0;
    enable = 1'b0;
    cyc(2);
    frame_q.push_back(mk(0, 0, 0, 0));
    frame_q.push_back(mk(0, 0, 0, 0));
    enable = 1'b1;
    wait_t(34);
  endtask

  task automatic test_leading_zero();
    frame_q.push_back(mk(0, 0, 5, 0));
    frame_q.push_back(mk(0, 0, 5, 0));
    digits_i = mk(0, 0, 5, 0);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    wait_t(74);
    total++; if (an !== 4'b1101) begin bad++; $display("FAIL lz_an_idx1: got %b required 1101", an); end
    total++; if (hex.digito !== 4'd5) begin bad++; $display("FAIL lz_hex_idx1: got %0d required 5", hex.digito); end
    wait_t(90);
    total++;
    if (an !== (LZB ? 4'hF : 4'b0111)) begin
      bad++; $display("FAIL lz_an_idx3: got %b required %b", an, (LZB ? 4'hF : 4'b0111));
    end
    wait_t(100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_scan();
    test_midframe_load();
    test_load_at_wrap();
    test_enable_abort();
    test_reset_mid_show();
    test_leading_zero();
    checking = 1'b0;
    total++;
    if (frame_q.size() != 0) begin
      bad++; $display("FAIL frame_q_left: got %0d unconsumed frames required 0", frame_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
